// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// N-digit BCD countdown for the bomb-defusal game core. Loads a BCD start
// time, counts down on one-second ticks, subtracts a BCD penalty on each
// strike, and flags expiry with a one-cycle pulse plus a held zero status.
module bcd_countdown_timer #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  strike,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   penalty,
    output logic [4*DIGITS-1:0]   value,
    output logic                  running,
    output logic                  paused,
    output logic                  zero,
    output logic                  expired
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSED  = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   load_clean;
    logic [W-1:0]   pen_clean;
    logic [W-1:0]   sub_amount;
    logic [W-1:0]   diff;
    logic           borrow_out;
    logic           hits_zero;

    // Any BCD digit above 9 is clamped to 9 so the display never shows garbage.
    function automatic logic [W-1:0] sanitise(input logic [W-1:0] x);
        logic [W-1:0] r;
        r = x;
        for (int i = 0; i < DIGITS; i++) begin
            if (x[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Ripple BCD subtract, LSD first. The tick is folded in as the initial
    // borrow, so penalty+1 never needs an extra digit of headroom. The MSB of
    // the result is the final borrow, meaning the true result went negative.
    function automatic logic [W:0] bcd_subtract(input logic [W-1:0] a,
                                                input logic [W-1:0] b,
                                                input logic         borrow_in);
        logic [W-1:0] d;
        logic         borrow;
        logic [4:0]   t;
        d      = '0;
        borrow = borrow_in;
        for (int i = 0; i < DIGITS; i++) begin
            t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, borrow};
            if (t[4]) begin
                d[4*i +: 4] = t[3:0] + 4'd10;
                borrow      = 1'b1;
            end else begin
                d[4*i +: 4] = t[3:0];
                borrow      = 1'b0;
            end
        end
        return {borrow, d};
    endfunction

    assign load_clean = sanitise(load_val);
    assign pen_clean  = sanitise(penalty);
    assign sub_amount = strike ? pen_clean : '0;
    assign {borrow_out, diff} = bcd_subtract(value, sub_amount, tick);
    assign hits_zero  = borrow_out || (diff == '0);

    assign running = (state == RUN);
    assign paused  = (state == PAUSED);
    assign zero    = (state == EXPIRED);

    // Main controller: state, displayed time and the expiry pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            value   <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    value <= load_clean;
                    if (arm) begin
                        if (load_clean != '0) begin
                            state <= RUN;
                        end else begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (pause) begin
                        state <= PAUSED;
                    end else if (hits_zero) begin
                        value   <= '0;
                        state   <= EXPIRED;
                        expired <= 1'b1;
                    end else begin
                        value <= diff;
                    end
                end
                PAUSED: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        state <= RUN;
                    end
                end
                EXPIRED: begin
                    if (abort) begin
                        state <= IDLE;
                        value <= '0;
                    end else if (arm) begin
                        value <= load_clean;
                        if (load_clean != '0) begin
                            state <= RUN;
                        end else begin
                            expired <= 1'b1;
                        end
                    end else begin
                        value <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    value <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
// Directed and randomized checks of bcd_countdown_timer against a decimal
// integer model of the countdown rules; a second 4-digit instance covers
// digit clamping and zero-load expiry.
module tb_bcd_countdown_timer;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSED  = 2;
    localparam int M_EXPIRED = 3;

    logic        clk = 1'b0;
    logic        reset, tick, arm, abort, pause, strike;
    logic [11:0] load_val, penalty;
    logic [11:0] value;
    logic        running, paused, zero, expired;

    logic        arm4, abort4;
    logic [15:0] load4;
    logic [15:0] value4;
    logic        running4, paused4, zero4, expired4;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int step_no = 0;

    int m_st  = M_IDLE;
    int m_val = 0;
    bit m_exp = 1'b0;

    // Free-running system clock.
    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(3)) dut (
        .clk(clk), .reset(reset), .tick(tick), .arm(arm), .abort(abort),
        .pause(pause), .strike(strike), .load_val(load_val), .penalty(penalty),
        .value(value), .running(running), .paused(paused), .zero(zero),
        .expired(expired)
    );

    bcd_countdown_timer #(.DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .tick(1'b0), .arm(arm4), .abort(abort4),
        .pause(1'b0), .strike(1'b0), .load_val(load4), .penalty(16'h0000),
        .value(value4), .running(running4), .paused(paused4), .zero(zero4),
        .expired(expired4)
    );

    // Decimal value of a 3-digit BCD word with digits above 9 read as 9.
    function automatic int san_int(input logic [11:0] x);
        int r = 0;
        int p = 1;
        for (int i = 0; i < 3; i++) begin
            int d;
            d = int'(x[4*i +: 4]);
            if (d > 9) d = 9;
            r += d * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the reference model by one clock using the inputs just sampled.
    task automatic modelStep();
        int ld;
        int nv;
        ld = san_int(load_val);
        if (!reset) begin
            m_st  = M_IDLE;
            m_val = 0;
            m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            case (m_st)
                M_IDLE: begin
                    m_val = ld;
                    if (arm) begin
                        if (ld == 0) begin m_st = M_EXPIRED; m_exp = 1'b1; end
                        else m_st = M_RUN;
                    end
                end
                M_RUN: begin
                    if (abort) m_st = M_IDLE;
                    else if (pause) m_st = M_PAUSED;
                    else begin
                        nv = m_val - ((strike ? san_int(penalty) : 0) + (tick ? 1 : 0));
                        if (nv <= 0) begin
                            m_val = 0; m_st = M_EXPIRED; m_exp = 1'b1;
                        end else begin
                            m_val = nv;
                        end
                    end
                end
                M_PAUSED: begin
                    if (abort) m_st = M_IDLE;
                    else if (!pause) m_st = M_RUN;
                end
                default: begin
                    if (abort) begin
                        m_st = M_IDLE; m_val = 0;
                    end else if (arm) begin
                        m_val = ld;
                        if (ld == 0) m_exp = 1'b1;
                        else m_st = M_RUN;
                    end else begin
                        m_val = 0;
                    end
                end
            endcase
        end
    endtask

    task automatic checkAll();
        checkOutput($sformatf("value@%0d", step_no), 32'(value), 32'(to_bcd(m_val)));
        checkOutput($sformatf("running@%0d", step_no), 32'(running), 32'(m_st == M_RUN));
        checkOutput($sformatf("paused@%0d", step_no), 32'(paused), 32'(m_st == M_PAUSED));
        checkOutput($sformatf("zero@%0d", step_no), 32'(zero), 32'(m_st == M_EXPIRED));
        checkOutput($sformatf("expired@%0d", step_no), 32'(expired), 32'(m_exp));
    endtask

    task automatic applyStimulus(input logic r, input logic a, input logic ab, input logic p,
                                 input logic s, input logic t,
                                 input logic [11:0] lv, input logic [11:0] pen);
        reset = r; arm = a; abort = ab; pause = p; strike = s; tick = t;
        load_val = lv; penalty = pen;
        @(posedge clk);
        modelStep();
        #1;
        step_no++;
        checkAll();
    endtask

    initial begin
        logic        pause_lvl;
        logic [11:0] rl;
        logic [11:0] rp;
        reset = 1'b0; arm = 1'b0; abort = 1'b0; pause = 1'b0; strike = 1'b0; tick = 1'b0;
        load_val = '0; penalty = '0;
        arm4 = 1'b0; abort4 = 1'b0; load4 = '0;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
        applyStimulus(0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
        checkOutput("rst_value", 32'(value), 32'h000);

        // Reset during RUN at 042, then preview of 120 after release
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h042, 12'h000);
        checkOutput("run_042", 32'(value), 32'h042);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h120, 12'h000);
        applyStimulus(0, 0, 0, 0, 0, 1, 12'h120, 12'h000);
        checkOutput("midrun_rst", 32'(value), 32'h000);
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h120, 12'h000);
        checkOutput("preview_120", 32'(value), 32'h120);

        // 100 counts down through a borrow chain
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h100, 12'h000);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0, 1, 12'h100, 12'h000);
        checkOutput("tick_097", 32'(value), 32'h097);

        // Expiry from 003, extra ticks stay at zero
        applyStimulus(1, 0, 1, 0, 0, 0, 12'h003, 12'h000);
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h003, 12'h000);
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, 1, 12'h003, 12'h000);
        checkOutput("expire_zero", 32'(zero), 32'h1);

        // Penalties: strike, zero penalty, strike+tick, strike past zero
        applyStimulus(1, 0, 1, 0, 0, 0, 12'h060, 12'h015);
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h060, 12'h015);
        applyStimulus(1, 0, 0, 0, 1, 0, 12'h060, 12'h015);
        checkOutput("strike_045", 32'(value), 32'h045);
        applyStimulus(1, 0, 0, 0, 1, 0, 12'h060, 12'h000);
        applyStimulus(1, 0, 0, 0, 1, 1, 12'h060, 12'h015);
        checkOutput("strike_tick_029", 32'(value), 32'h029);
        applyStimulus(1, 0, 1, 0, 0, 0, 12'h010, 12'h015);
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h010, 12'h015);
        applyStimulus(1, 0, 0, 0, 1, 0, 12'h010, 12'h015);
        checkOutput("strike_expire", 32'(expired), 32'h1);

        // Pause freezes ticks and strikes
        applyStimulus(1, 0, 1, 0, 0, 0, 12'h050, 12'h015);
        applyStimulus(1, 1, 0, 0, 0, 0, 12'h050, 12'h015);
        applyStimulus(1, 0, 0, 1, 0, 1, 12'h050, 12'h015);
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 1, 0, 1, 12'h050, 12'h015);
        applyStimulus(1, 0, 0, 1, 1, 0, 12'h050, 12'h015);
        checkOutput("paused_050", 32'(value), 32'h050);
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h050, 12'h015);
        applyStimulus(1, 0, 0, 0, 0, 1, 12'h050, 12'h015);
        checkOutput("resume_049", 32'(value), 32'h049);

        // Four-digit instance: clamped load, abort, zero load
        load4 = 16'hA000; arm4 = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h050, 12'h015);
        checkOutput("d4_value_9000", 32'(value4), 32'h9000);
        checkOutput("d4_running", 32'(running4), 32'h1);
        arm4 = 1'b0; abort4 = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h050, 12'h015);
        checkOutput("d4_abort_idle", 32'(running4), 32'h0);
        abort4 = 1'b0; load4 = 16'h0000; arm4 = 1'b1;
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h050, 12'h015);
        checkOutput("d4_zero_load", 32'(zero4), 32'h1);
        checkOutput("d4_pulse", 32'(expired4), 32'h1);
        checkOutput("d4_value_0", 32'(value4), 32'h0);
        arm4 = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 0, 12'h050, 12'h015);
        checkOutput("d4_pulse_end", 32'(expired4), 32'h0);
        checkOutput("d4_zero_held", 32'(zero4), 32'h1);

        // Randomized traffic against the model
        pause_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(9) == 0) pause_lvl = ~pause_lvl;
            rl = 12'($urandom);
            rp = {4'h0, 4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            applyStimulus(($urandom_range(63) != 0), ($urandom_range(7) == 0),
                          ($urandom_range(31) == 0), pause_lvl,
                          ($urandom_range(5) == 0), ($urandom_range(1) == 0), rl, rp);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised N-digit BCD countdown timer for the bomb-defusal game core; it replaces the fixed 3-digit countdown.
- Loads a BCD start time, then decrements once per one-second tick.
- Supports pause/resume and abort.
- Subtracts a BCD time penalty on each strike.
- Flags expiry with a one-cycle pulse and a held status. Outputs drive the seven-segment digit decoders and the game-over logic.

Parameters:
- DIGITS, 3, number of BCD digits; value width is 4*DIGITS; range 1..8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  one-cycle pulse per second from the prescaler
- arm  in  1  one-cycle start request; loads load_val
- abort  in  1  one-cycle request to return to IDLE
- pause  in  1  level; while high the countdown is frozen
- strike  in  1  one-cycle pulse; subtract penalty
- load_val  in  4*DIGITS  BCD start time; digit 0 is the LSD
- penalty  in  4*DIGITS  BCD penalty amount
- value  out  4*DIGITS  current BCD time
- running  out  1  high in RUN
- paused  out  1  high in PAUSED
- zero  out  1  high in EXPIRED
- expired  out  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- Reset (reset==0 at posedge clk) has priority over all other inputs, including mid-countdown.
  - State = IDLE, value = 0, expired = 0, and running/paused/zero = 0.
- All outputs are registered.
  - running, paused and zero are decoded from the state register.
- States: IDLE, RUN, PAUSED, EXPIRED.

- IDLE:
  - value <= sanitised load_val every cycle, so the display previews the start time.
  - arm=1: value <= sanitised load_val.
    - If that value is nonzero, go to RUN.
    - If it is zero, go to EXPIRED with an expired pulse.
  - tick, strike, pause and abort are ignored.
- RUN (input priority: abort > pause > strike/tick):
  - abort: go to IDLE; value <= load_val on the following cycles.
  - pause=1: go to PAUSED; value is unchanged, and a strike/tick in the same cycle is dropped.
  - Otherwise value <= value - d, where d = (strike ? penalty : 0) + (tick ? 1 : 0), computed in BCD.
  - If the result is <= 0, value <= 0, state goes to EXPIRED and expired = 1 for one cycle.
  - arm is ignored (no re-arm while running).
- PAUSED:
  - tick and strike are ignored.
  - abort: go to IDLE.
  - pause=0: go to RUN; the next tick resumes the decrement.
- EXPIRED:
  - value holds 0 and zero = 1.
  - abort: go to IDLE.
  - arm: reload from load_val as in IDLE.
  - tick, strike and pause are ignored.
- Sanitising: any load_val digit greater than 9 is clamped to 9 on load. A penalty digit greater than 9 is treated as 9.
- BCD arithmetic: multi-digit subtract with borrow, LSD first.
  - A digit that borrows through 0 becomes 9. Example: 100 - 1 = 099; 070 - 015 = 055.
  - Underflow past all digits saturates to all zeros and never wraps.
- Latency:
  - A tick or strike sampled at edge n is visible on value after edge n.
  - expired asserts in the same cycle value becomes 0.
- Simultaneous strike and tick in RUN subtract penalty+1 in one step.
- Penalty 0 with strike only leaves value unchanged.
- Timing is not cycle-count based: the block never self-generates ticks.

Test Plan:
- Reset low for 2 cycles during RUN at value 042 -> value=000, state IDLE, running=0, zero=0, expired=0; with load_val=120 applied, value=120 one cycle after reset rises.
- load_val=100, arm, then 3 ticks -> value 099, 098, 097 after the respective edges; running=1 throughout.
- Run at value 003, then 3 ticks -> value 002, 001, 000; on the third tick expired=1 for exactly one cycle, zero=1 held, running=0; further ticks keep value 000.
- Value 060 with penalty=015: strike alone -> 045; strike+tick in the same cycle -> 029; value 010 with strike (penalty 015) -> 000 and expired pulse.
- Value 050, pause=1 with a tick in the same cycle -> value stays 050, paused=1; 4 ticks and 1 strike while paused -> still 050; pause=0 then a tick -> 049.
- DIGITS=4, load_val=0xA000 (invalid digit), arm -> value=9000; abort -> IDLE next cycle; arm with load_val=0000 -> EXPIRED immediately with an expired pulse.
